// File: rtl/wave_gen_param.sv
// wave_gen_param
//   Counter-based waveform generator with double-buffered settings.
//   Period, PulseWidth and WaveType are captured into shadow registers only
//   when a new period starts (terminal count reached or hard sync), so the
//   output never changes shape mid-period.
//
// Ports
//   Clock       in   system clock, rising edge
//   ResetN      in   synchronous active-low reset (highest priority)
//   Enable      in   1 = counter advances, 0 = counter holds
//   Sync        in   hard sync: restart period and load settings now
//   Period      in   terminal count; output period is Period+1 clocks
//   PulseWidth  in   square-mode high time in clocks
//   WaveType    in   00 saw up, 01 square, 10 triangle, 11 saw down
//   Waveform    out  registered sample, one clock behind the counter
//   Wrap        out  one-cycle strobe when a new period starts
module wave_gen_param #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Enable,
  input  logic             Sync,
  input  logic [WIDTH-1:0] Period,
  input  logic [WIDTH-1:0] PulseWidth,
  input  logic [1:0]       WaveType,
  output logic [WIDTH-1:0] Waveform,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] pw_q, pw_d;
  logic [1:0]       type_q, type_d;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic             wrap_q, wrap_d;

  logic at_end;
  logic load;

  assign at_end = (cnt_q == per_q);
  // A new period starts on hard sync, or on an enabled edge at terminal count.
  assign load   = Sync || (Enable && at_end);

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    pw_d   = pw_q;
    type_d = type_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d  = '0;
      per_d  = Period;
      pw_d   = PulseWidth;
      type_d = WaveType;
      wrap_d = 1'b1;
    end else if (Enable) begin
      // Only reached when cnt_q != per_q, so the increment never passes per_q.
      cnt_d = cnt_q + ONE;
    end
  end

  // Sample is a function of the pre-edge counter and shadows.
  always_comb begin
    wave_d = '0;
    case (type_q)
      2'b00: wave_d = cnt_q;
      2'b01: wave_d = (cnt_q < pw_q) ? '1 : '0;
      // Rising half up to per_q>>1, then descending back toward 1; the
      // +1 keeps both halves symmetric for odd periods (wraps mod 2^WIDTH).
      2'b10: wave_d = (cnt_q <= (per_q >> 1)) ? cnt_q : (per_q - cnt_q + ONE);
      2'b11: wave_d = per_q - cnt_q;
      default: wave_d = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      cnt_q  <= '0;
      per_q  <= '0;
      pw_q   <= '0;
      type_q <= 2'b00;
      wave_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      pw_q   <= pw_d;
      type_q <= type_d;
      wave_q <= wave_d;
      wrap_q <= wrap_d;
    end
  end

  assign Waveform = wave_q;
  assign Wrap     = wrap_q;

endmodule

// File: tb/tb_wave_gen_param.sv
module tb_wave_gen_param;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         Clock = 1'b0;
  logic         ResetN;
  logic         Enable;
  logic         Sync;
  logic [W-1:0] Period;
  logic [W-1:0] PulseWidth;
  logic [1:0]   WaveType;
  logic [W-1:0] Waveform;
  logic         Wrap;

  int checks   = 0;
  int failures = 0;

  wave_gen_param #(.WIDTH(W)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .Enable     (Enable),
    .Sync       (Sync),
    .Period     (Period),
    .PulseWidth (PulseWidth),
    .WaveType   (WaveType),
    .Waveform   (Waveform),
    .Wrap       (Wrap)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: integer position within the period plus the settings
  // captured at the start of that period.
  int m_pos = 0, m_per = 0, m_pw = 0, m_typ = 0;
  int exp_wave = 0;
  int exp_wrap = 0;
  bit chk_en = 1'b0;

  function automatic int shape(int pos, int per, int pw, int typ);
    int r;
    case (typ)
      0: r = pos;
      1: r = (pos < pw) ? MASK : 0;
      2: r = (pos <= per / 2) ? pos : ((per - pos + 1) & MASK);
      default: r = per - pos;
    endcase
    return r;
  endfunction

  always @(posedge Clock) begin
    if (!ResetN) begin
      m_pos <= 0; m_per <= 0; m_pw <= 0; m_typ <= 0;
      exp_wave <= 0; exp_wrap <= 0;
    end else begin
      exp_wave <= shape(m_pos, m_per, m_pw, m_typ);
      if (Sync || (Enable && m_pos == m_per)) begin
        m_pos <= 0;
        m_per <= int'(Period);
        m_pw  <= int'(PulseWidth);
        m_typ <= int'(WaveType);
        exp_wrap <= 1;
      end else begin
        if (Enable) m_pos <= m_pos + 1;
        exp_wrap <= 0;
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      checks++;
      if (int'(Waveform) != exp_wave || Waveform === 'x) begin
        failures++;
        $display("FAIL model_wave t=%0t got=%0d want=%0d", $time, Waveform, exp_wave);
      end
      checks++;
      if (Wrap !== exp_wrap[0]) begin
        failures++;
        $display("FAIL model_wrap t=%0t got=%b want=%0d", $time, Wrap, exp_wrap);
      end
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic lit(string nm, logic [W-1:0] got, int want);
    checks++;
    if (got !== want[W-1:0]) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  int ew[$];
  int er[$];

  task automatic check_seq(string nm);
    for (int i = 0; i < ew.size(); i++) begin
      tick();
      lit($sformatf("%s_wave[%0d]", nm, i), Waveform, ew[i]);
      if (er.size() > 0)
        lit($sformatf("%s_wrap[%0d]", nm, i), {{(W-1){1'b0}}, Wrap}, er[i]);
    end
  endtask

  task automatic sync_load(int per, int pw, int typ);
    Period = per[W-1:0]; PulseWidth = pw[W-1:0]; WaveType = typ[1:0];
    Sync = 1'b1;
    tick();
    Sync = 1'b0;
  endtask

  initial begin
    ResetN = 1'b0; Enable = 1'b0; Sync = 1'b0;
    Period = '0; PulseWidth = '0; WaveType = 2'b00;
    tick(); tick();
    chk_en = 1'b1;
    lit("reset_wave", Waveform, 0);
    lit("reset_wrap", {{(W-1){1'b0}}, Wrap}, 0);

    // Test 1: first enabled edge wraps and loads, then saw 0..3
    ResetN = 1'b1; Period = 8'd3; WaveType = 2'b00; Enable = 1'b1;
    tick();
    lit("t1_first_wrap", {{(W-1){1'b0}}, Wrap}, 1);
    lit("t1_first_wave", Waveform, 0);
    ew = '{0, 1, 2, 3, 0, 1, 2, 3};
    er = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_seq("t1");

    // Test 2: square with different pulse widths
    sync_load(9, 3, 1);
    ew = '{255, 255, 255, 0, 0, 0, 0, 0, 0, 0};
    er = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    check_seq("t2_pw3");
    sync_load(9, 0, 1);
    ew = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    er.delete();
    check_seq("t2_pw0");
    sync_load(9, 12, 1);
    ew = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255};
    check_seq("t2_pw12");

    // Test 3: triangle and saw down
    sync_load(7, 0, 2);
    ew = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1};
    check_seq("t3_tri");
    sync_load(7, 0, 3);
    ew = '{7, 6, 5, 4, 3, 2, 1, 0};
    check_seq("t3_down");

    // Test 4: mid-period change only takes effect at the next wrap
    sync_load(7, 0, 0);
    tick(); tick();
    Period = 8'd3; WaveType = 2'b01; PulseWidth = 8'd2;
    ew = '{2, 3, 4, 5, 6, 7, 255, 255, 0, 0, 255};
    er = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    check_seq("t4");

    // Test 5: hard sync mid-period, then enable hold
    sync_load(9, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    lit("t5_pre_sync_wave", Waveform, 4);
    Period = 8'd4; Sync = 1'b1;
    tick();
    Sync = 1'b0;
    lit("t5_sync_wrap", {{(W-1){1'b0}}, Wrap}, 1);
    lit("t5_sync_wave", Waveform, 5);
    tick();
    lit("t5_after_sync", Waveform, 0);
    Enable = 1'b0;
    ew = '{1, 1, 1};
    er = '{0, 0, 0};
    check_seq("t5_hold");
    Sync = 1'b1;
    tick();
    Sync = 1'b0;
    lit("t5_sync_disabled_wrap", {{(W-1){1'b0}}, Wrap}, 1);
    tick();
    lit("t5_sync_disabled_wave", Waveform, 0);
    Enable = 1'b1;

    // Period = 0: wrap every enabled clock, outputs 0
    sync_load(0, 0, 2);
    ew = '{0, 0, 0, 0};
    er = '{1, 1, 1, 1};
    check_seq("p0_tri");

    // Period = all-ones: full 256-clock period
    sync_load(MASK, 0, 0);
    for (int i = 0; i < 255; i++) tick();
    lit("pmax_wave_254", Waveform, 254);
    tick();
    lit("pmax_wave_255", Waveform, 255);
    lit("pmax_wrap", {{(W-1){1'b0}}, Wrap}, 1);
    tick();
    lit("pmax_wave_rollover", Waveform, 0);

    // Test 6: reset mid-operation overrides Sync/Enable
    sync_load(9, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    ResetN = 1'b0; Sync = 1'b1;
    tick();
    lit("t6_reset_wave", Waveform, 0);
    lit("t6_reset_wrap", {{(W-1){1'b0}}, Wrap}, 0);
    ResetN = 1'b1; Sync = 1'b0; Period = 8'd3; WaveType = 2'b00; Enable = 1'b1;
    tick();
    lit("t6_first_wrap", {{(W-1){1'b0}}, Wrap}, 1);
    ew = '{0, 1, 2, 3, 0, 1, 2, 3};
    er = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_seq("t6");

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_gen_param.md
Name: wave_gen_param

Overview:
Parametrised successor to the 8-bit oscillator: a counter-based waveform generator with configurable width, programmable pulse width, four wave modes, enable, hard sync and a period-wrap strobe. Settings are double-buffered and applied only at period boundaries, so changes never glitch mid-period. It sits between the note/parameter control logic and the mixer/DAC path.

Parameters:
WIDTH, 8, width of counter, Period, PulseWidth and Waveform

Ports:
Clock  input  1  system clock; all logic on rising edge
ResetN  input  1  synchronous active-low reset
Enable  input  1  1 = counter advances; 0 = counter holds
Sync  input  1  hard sync: restart period immediately (oscillator sync)
Period  input  WIDTH  terminal count; output period = Period+1 clocks
PulseWidth  input  WIDTH  square-mode high time in clocks
WaveType  input  2  00 saw up, 01 square, 10 triangle, 11 saw down
Waveform  output  WIDTH  registered sample
Wrap  output  1  one-cycle strobe when a new period starts

Behaviour:
- Reset/clock: one clock, Clock. Reset is synchronous and active-low on ResetN; it has priority over every other input.
- State: cnt (WIDTH) plus active shadow registers per_q, pw_q and type_q.
- Reset values: cnt=0, per_q=0, pw_q=0, type_q=00, Waveform=0, Wrap=0.
- Priority per edge when not in reset: Sync, then the Enable wrap/advance step, then hold.
- Sync=1, regardless of Enable:
  - cnt<=0
  - load per_q<=Period, pw_q<=PulseWidth, type_q<=WaveType
  - Wrap<=1
- Enable=1, Sync=0, cnt==per_q: cnt<=0, same shadow load, Wrap<=1.
- Enable=1, Sync=0, cnt!=per_q: cnt<=cnt+1, Wrap<=0.
- Enable=0, Sync=0: cnt and shadows hold, Wrap<=0.
- Because per_q=0 at reset, the first enabled edge after reset wraps and loads the inputs.
- cnt never exceeds per_q: shadows only load when cnt returns to 0.
- Period, PulseWidth and WaveType are ignored except on wrap/Sync edges; mid-period changes take effect at the next period start.
- Waveform is registered every non-reset edge, including Enable=0. It is f(cnt, per_q, pw_q, type_q) of the pre-edge values, so latency is 1 clock after the counter value.
  - 00: cnt
  - 01: cnt < pw_q ? all-ones : 0. pw_q=0 gives constant 0; pw_q>per_q gives constant all-ones.
  - 10: cnt <= (per_q>>1) ? cnt : per_q-cnt+1, computed modulo 2^WIDTH
  - 11: per_q-cnt
- Period=0: wraps every enabled clock; Wrap stays high continuously; saw/triangle output 0.
- Period=all-ones: full 2^WIDTH-clock period; cnt+1 must not be evaluated past per_q.
- Reset mid-operation: next edge returns all state to reset values, regardless of Sync/Enable.

Test Plan:
1. Reset, then Period=3, saw, Enable=1 → first edge wraps/loads. Waveform then repeats 0,1,2,3 (after 1-clock latency); Wrap high 1 clock every 4.
2. Period=9, PulseWidth=3, square → per 10-clock period: 3 samples 0xFF then 7 samples 0x00; PulseWidth=0 → all 0x00; PulseWidth=12 → all 0xFF.
3. Period=7, triangle → 0,1,2,3,4,3,2,1 repeating. WaveType=11 → 7,6,5,4,3,2,1,0.
4. Period changed 7→3 and WaveType saw→square while cnt=2 → current period completes through cnt=7 in saw; the next period is 4 clocks in square.
5. Sync=1 at cnt=5 (Period=9) → next edge cnt=0, Wrap=1, new inputs loaded. Enable=0 for 3 clocks → cnt and Waveform frozen, Wrap=0.
6. ResetN low for one edge at cnt=5 → Waveform=0, Wrap=0, cnt=0. Next enabled edge wraps and reloads; the sequence restarts as in test 1.
